fft_frame_streamer: RTL and testbench

Audio-to-FFT frame packer for the tuner datapath. Accepts left-channel samples from the audio controller's read strobe, buffers them in a small FIFO, and drives the FFT core's Avalon-ST sink with fixed-length frames. Generates sop/eop framing, honours `sink_ready` backpressure, and reports dropped samples.

---
 rtl/fft_frame_streamer.sv | 235 +++++++++++++++++++++++
 tb/tb_fft_frame_streamer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer
//
// Packs left-channel audio samples into fixed-length frames for the FFT core's
// Avalon-ST sink. Samples pass through a small FIFO into a one-beat output
// register. The first beat of each frame carries sop and the last carries eop.
// The streamer honours sink_ready backpressure and keeps a sticky overflow flag
// for samples that arrive while the FIFO is full.
//
// Optional build macro: FFT_STREAMER_DECIM_EN
//   When defined, a decimate-by-2 averager sits in front of the FIFO. Each pair
//   of strobes writes (a+b)>>>1 one cycle after the second strobe.
//
// Ports:
//   CLOCK_50      system clock (single domain)
//   reset         synchronous, active-high reset
//   enable        permits starting a new frame (sampled only in IDLE)
//   sample_valid  one-cycle strobe qualifying sample_in
//   sample_in     32-bit signed audio sample
//   sink_valid    Avalon-ST valid to the FFT
//   sink_ready    Avalon-ST ready from the FFT
//   sink_sop      first beat of frame
//   sink_eop      last beat of frame
//   sink_error    constant 2'b00
//   sink_real     truncated sample (top DATA_W bits)
//   sink_imag     constant 0
//   fftpts_in     constant FFT_POINTS
//   frame_done    one-cycle pulse after the eop beat transfers
//   overflow      sticky, set when a sample is dropped
//   fifo_level    current FIFO occupancy

module fft_frame_streamer #(
  parameter int FFT_POINTS = 1024,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            sample_valid,
  input  logic [31:0]                     sample_in,
  output logic                            sink_valid,
  input  logic                            sink_ready,
  output logic                            sink_sop,
  output logic                            sink_eop,
  output logic [1:0]                      sink_error,
  output logic [DATA_W-1:0]               sink_real,
  output logic [DATA_W-1:0]               sink_imag,
  output logic [$clog2(FFT_POINTS):0]     fftpts_in,
  output logic                            frame_done,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int CNT_W = $clog2(FFT_POINTS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FFT_POINTS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  logic               wr_en;
  logic [DATA_W-1:0]  wr_data;

  assign sink_error = 2'b00;
  assign sink_imag  = '0;
  assign fftpts_in  = (CNT_W + 1)'(FFT_POINTS);

`ifdef FFT_STREAMER_DECIM_EN
  // Decimate-by-2 front end: hold the first sample of each pair, then register
  // the 33-bit average of the pair so the FIFO write lands one cycle after the
  // second strobe.
  logic               phase;
  logic [31:0]        first_sample;
  logic               wr_en_q;
  logic [DATA_W-1:0]  wr_data_q;
  logic signed [32:0] pair_sum;
  logic               unused_sum_bits;

  assign pair_sum = $signed({first_sample[31], first_sample}) +
                    $signed({sample_in[31], sample_in});
  // Bit 32 of the sum is bit 31 of (sum >>> 1), so this slice is the
  // averaged sample truncated to its top DATA_W bits.
  assign unused_sum_bits = ^pair_sum[32-DATA_W:0];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      phase        <= 1'b0;
      first_sample <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (sample_valid) begin
        if (!phase) begin
          first_sample <= sample_in;
          phase        <= 1'b1;
        end else begin
          phase     <= 1'b0;
          wr_en_q   <= 1'b1;
          wr_data_q <= pair_sum[32:33-DATA_W];
        end
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
`else
  logic unused_sample_bits;

  assign wr_en              = sample_valid;
  assign wr_data            = sample_in[31:32-DATA_W];
  assign unused_sample_bits = ^sample_in[31-DATA_W:0];
`endif

  logic              fifo_empty;
  logic              fifo_full;
  logic              xfer;
  logic              load_idle;
  logic              load_stream;
  logic              pop;
  logic              push;
  logic [CNT_W-1:0]  next_idx;

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign xfer       = sink_valid && sink_ready;

  // The output register refills while its current beat transfers, except
  // after the eop beat: the next frame must start from IDLE with a fresh sop.
  assign load_idle   = (state == IDLE) && enable && !fifo_empty && !sink_valid;
  assign load_stream = (state == STREAM) && !fifo_empty &&
                       (!sink_valid || (xfer && !sink_eop));
  assign pop  = load_idle || load_stream;
  assign push = wr_en && (!fifo_full || pop);

  // Index of the beat about to be loaded. beat_cnt counts completed
  // transfers, so a beat loaded behind a transferring one is one further on.
  assign next_idx = sink_valid ? beat_cnt + CNT_W'(1) : beat_cnt;

  // FIFO storage has no reset; emptiness is tracked by the pointers and level.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy. A full FIFO that pops in the same cycle
  // still accepts the write.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky drop flag: only reset clears it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_en && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // Frame FSM with the registered Avalon-ST beat.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      sink_valid <= 1'b0;
      sink_sop   <= 1'b0;
      sink_eop   <= 1'b0;
      sink_real  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (load_idle) begin
            state      <= STREAM;
            sink_valid <= 1'b1;
            sink_sop   <= 1'b1;
            sink_eop   <= (LAST_BEAT == '0);
            sink_real  <= mem[rd_ptr];
          end
        end
        STREAM: begin
          if (xfer) begin
            if (sink_eop) begin
              beat_cnt   <= '0;
              state      <= IDLE;
              frame_done <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
          if (load_stream) begin
            sink_valid <= 1'b1;
            sink_sop   <= 1'b0;
            sink_eop   <= (next_idx == LAST_BEAT);
            sink_real  <= mem[rd_ptr];
          end else if (xfer) begin
            sink_valid <= 1'b0;
            sink_sop   <= 1'b0;
            sink_eop   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// tb_fft_frame_streamer
//
// Directed self-checking bench for fft_frame_streamer with default parameters
// (1024-point frames, 16-bit data, 16-entry FIFO). Stimulus samples carry their
// index in the top 16 bits, so sink_real reads back as the sample index.
// Building with FFT_STREAMER_DECIM_EN runs the averager sequence instead of
// the direct-path sequence.

module tb_fft_frame_streamer;

  localparam int N     = 1024;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic              CLOCK_50 = 1'b0;
  logic              reset;
  logic              enable;
  logic              sample_valid;
  logic [31:0]       sample_in;
  logic              sink_valid;
  logic              sink_ready;
  logic              sink_sop;
  logic              sink_eop;
  logic [1:0]        sink_error;
  logic [DW-1:0]     sink_real;
  logic [DW-1:0]     sink_imag;
  logic [10:0]       fftpts_in;
  logic              frame_done;
  logic              overflow;
  logic [4:0]        fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  fft_frame_streamer #(
    .FFT_POINTS (N),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_error   (sink_error),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .fftpts_in    (fftpts_in),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .fifo_level   (fifo_level)
  );

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d);
    sample_valid = v;
    sample_in    = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int fed;
    int beats;
    int bad;
    int dones;
    int unstable;
    int expect_idx;
    int drained;

    reset      = 1'b1;
    enable     = 1'b0;
    sink_ready = 1'b0;
    applyStimulus(1'b0, 32'h0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_valid",   32'(sink_valid), 32'd0);
    checkOutput("rst_sop",     32'(sink_sop),   32'd0);
    checkOutput("rst_eop",     32'(sink_eop),   32'd0);
    checkOutput("rst_done",    32'(frame_done), 32'd0);
    checkOutput("rst_ovf",     32'(overflow),   32'd0);
    checkOutput("rst_real",    32'(sink_real),  32'd0);
    checkOutput("rst_level",   32'(fifo_level), 32'd0);
    checkOutput("const_imag",  32'(sink_imag),  32'd0);
    checkOutput("const_error", 32'(sink_error), 32'd0);
    checkOutput("const_pts",   32'(fftpts_in),  32'd1024);

`ifdef FFT_STREAMER_DECIM_EN
    $display("[TB] decimating averager");
    sink_ready = 1'b1;
    applyStimulus(1'b1, 32'd100);      tick();
    applyStimulus(1'b1, 32'd200);      tick();
    applyStimulus(1'b1, 32'hFFFF_FFF9); tick();
    applyStimulus(1'b1, 32'hFFFF_FFF7); tick();
    applyStimulus(1'b1, 32'h0002_0000); tick();
    applyStimulus(1'b1, 32'h0004_0000); tick();
    applyStimulus(1'b0, 32'h0);
    tick();
    tick();
    checkOutput("decim_level", 32'(fifo_level), 32'd3);
    checkOutput("decim_ovf",   32'(overflow),   32'd0);
    enable = 1'b1;
    tick();
    checkOutput("decim_beat0_valid", 32'(sink_valid), 32'd1);
    checkOutput("decim_beat0_real",  32'(sink_real),  32'h0000);
    tick();
    checkOutput("decim_beat1_real",  32'(sink_real),  32'hFFFF);
    tick();
    checkOutput("decim_beat2_real",  32'(sink_real),  32'h0003);
    tick();
    checkOutput("decim_level_end",   32'(fifo_level), 32'd0);
`else
    $display("[TB] latency and truncation");
    enable     = 1'b1;
    sink_ready = 1'b0;
    applyStimulus(1'b1, 32'h8000_1234);
    tick();
    applyStimulus(1'b0, 32'h0);
    checkOutput("lat_valid_early", 32'(sink_valid), 32'd0);
    checkOutput("lat_level_one",   32'(fifo_level), 32'd1);
    tick();
    checkOutput("lat_valid",  32'(sink_valid), 32'd1);
    checkOutput("lat_sop",    32'(sink_sop),   32'd1);
    checkOutput("trunc_neg",  32'(sink_real),  32'h8000);
    checkOutput("lat_level0", 32'(fifo_level), 32'd0);
    applyStimulus(1'b1, 32'h7FFF_FFFF);
    tick();
    applyStimulus(1'b0, 32'h0);
    sink_ready = 1'b1;
    tick();
    sink_ready = 1'b0;
    checkOutput("trunc_pos",   32'(sink_real),  32'h7FFF);
    checkOutput("beat1_sop",   32'(sink_sop),   32'd0);
    checkOutput("beat1_valid", 32'(sink_valid), 32'd1);

    $display("[TB] reset mid-frame");
    sink_ready = 1'b1;
    for (int i = 0; i < 98; i++) begin
      applyStimulus(1'b1, 32'(i) << 16);
      tick();
    end
    applyStimulus(1'b0, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_valid", 32'(sink_valid), 32'd0);
    checkOutput("midrst_sop",   32'(sink_sop),   32'd0);
    checkOutput("midrst_real",  32'(sink_real),  32'd0);
    checkOutput("midrst_level", 32'(fifo_level), 32'd0);

    $display("[TB] enable handling and full frame");
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'(i) << 16);
      tick();
    end
    applyStimulus(1'b0, 32'h0);
    tick();
    tick();
    checkOutput("en_off_valid", 32'(sink_valid), 32'd0);
    checkOutput("en_off_level", 32'(fifo_level), 32'd5);
    enable = 1'b1;
    tick();
    checkOutput("en_on_valid", 32'(sink_valid), 32'd1);
    checkOutput("en_on_sop",   32'(sink_sop),   32'd1);

    fed   = 5;
    beats = 0;
    bad   = 0;
    dones = 0;
    for (int cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
      if (sink_valid && sink_ready) begin
        if (sink_real !== 16'(beats) || sink_sop !== (beats == 0) ||
            sink_eop !== (beats == N - 1)) begin
          bad++;
        end
        beats++;
        if (beats == 500) enable = 1'b0;
      end
      if (fed < N) begin
        applyStimulus(1'b1, 32'(fed) << 16);
        fed++;
      end else begin
        applyStimulus(1'b0, 32'h0);
      end
      tick();
      if (frame_done) dones++;
    end
    applyStimulus(1'b0, 32'h0);
    checkOutput("frame_beats",     32'(beats), 32'd1024);
    checkOutput("frame_bad_beats", 32'(bad),   32'd0);
    checkOutput("frame_done_seen", 32'(dones), 32'd1);
    tick();
    checkOutput("frame_done_pulse", 32'(frame_done), 32'd0);
    checkOutput("frame_end_valid",  32'(sink_valid), 32'd0);
    checkOutput("frame_end_level",  32'(fifo_level), 32'd0);

    $display("[TB] full FIFO with simultaneous pop");
    enable     = 1'b0;
    sink_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 32'(256 + i) << 16);
      tick();
    end
    applyStimulus(1'b0, 32'h0);
    tick();
    checkOutput("full_level", 32'(fifo_level), 32'd16);
    enable = 1'b1;
    applyStimulus(1'b1, 32'h0200_0000);
    tick();
    applyStimulus(1'b0, 32'h0);
    checkOutput("fullpop_level", 32'(fifo_level), 32'd16);
    checkOutput("fullpop_ovf",   32'(overflow),   32'd0);
    checkOutput("fullpop_sop",   32'(sink_sop),   32'd1);
    checkOutput("fullpop_real",  32'(sink_real),  32'h0100);

    $display("[TB] backpressure and overflow");
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    enable     = 1'b1;
    sink_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'(i) << 16);
      tick();
    end
    applyStimulus(1'b0, 32'h0);
    repeat (3) tick();
    sink_ready = 1'b0;
    applyStimulus(1'b1, 32'(3) << 16);
    tick();
    applyStimulus(1'b0, 32'h0);
    tick();
    tick();
    checkOutput("bp_hold_valid", 32'(sink_valid), 32'd1);
    checkOutput("bp_hold_real",  32'(sink_real),  32'd3);

    unstable = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 2 == 0) applyStimulus(1'b1, 32'(4 + c / 2) << 16);
      else            applyStimulus(1'b0, 32'h0);
      tick();
      if (!sink_valid || sink_real !== 16'd3) unstable++;
    end
    applyStimulus(1'b0, 32'h0);
    checkOutput("bp_stable", 32'(unstable),   32'd0);
    checkOutput("bp_level",  32'(fifo_level), 32'd16);
    checkOutput("bp_ovf",    32'(overflow),   32'd1);

    sink_ready = 1'b1;
    expect_idx = 3;
    drained    = 0;
    bad        = 0;
    for (int c = 0; c < 40; c++) begin
      if (sink_valid && sink_ready) begin
        if (sink_real !== 16'(expect_idx)) bad++;
        expect_idx++;
        drained++;
      end
      tick();
    end
    checkOutput("drain_count",   32'(drained),    32'd17);
    checkOutput("drain_order",   32'(bad),        32'd0);
    checkOutput("drain_level",   32'(fifo_level), 32'd0);
    checkOutput("drain_ovf_sticky", 32'(overflow), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
